// File: rtl/kvs_lookup_client.sv
// rtl/kvs_lookup_client.sv - requester endpoint for key/flag lookups with in-order tag tracking and timeout
module kvs_lookup_client #(
  parameter int KEY_SIZE   = 96,
  parameter int FLAG_SIZE  = 4,
  parameter int TAG_WIDTH  = 8,
  parameter int DEPTH_LOG2 = 3,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_mem,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [KEY_SIZE-1:0]   req_key,
  input  logic [FLAG_SIZE-1:0]  req_flag,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic [KEY_SIZE-1:0]   in_key,
  output logic [FLAG_SIZE-1:0]  in_flag,
  output logic                  in_valid,
  input  logic                  in_ready,
  input  logic                  out_valid,
  input  logic [FLAG_SIZE-1:0]  out_flag,
  output logic                  rsp_valid,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic [FLAG_SIZE-1:0]  rsp_flag,
  output logic                  rsp_timeout,
  output logic [DEPTH_LOG2:0]   inflight,
  output logic                  err_unexpected
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [DEPTH_LOG2:0] LP_DEPTH    = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [TMR_W-1:0]    LP_TMR_LAST = TMR_W'(TIMEOUT - 1);

  // Output stage toward the store
  logic                  r_in_valid;
  logic [KEY_SIZE-1:0]   r_in_key;
  logic [FLAG_SIZE-1:0]  r_in_flag;
  logic [TAG_WIDTH-1:0]  r_stage_tag;

  // In-order tag FIFO of requests handed to the store
  logic [TAG_WIDTH-1:0]  r_tag_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;

  // Head-of-queue response timer
  logic [TMR_W-1:0]      r_timer;

  // Verdict registers
  logic                  r_rsp_valid;
  logic [TAG_WIDTH-1:0]  r_rsp_tag;
  logic [FLAG_SIZE-1:0]  r_rsp_flag;
  logic                  r_rsp_timeout;
  logic                  r_err;

  logic [DEPTH_LOG2:0]   w_occ;
  logic                  w_req_ready;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_empty;
  logic                  w_rsp_pop;
  logic                  w_timeout;
  logic                  w_pop;
  logic [TAG_WIDTH-1:0]  w_head_tag;

  // Occupancy seen by the acceptance check counts the staged request but ignores a same-cycle pop
  assign w_occ       = r_count + {{DEPTH_LOG2{1'b0}}, r_in_valid};
  assign w_req_ready = !rst && !init_mem && (!r_in_valid || in_ready) && (w_occ < LP_DEPTH);
  assign w_accept    = req_valid && w_req_ready;
  assign w_push      = r_in_valid && in_ready;
  assign w_empty     = (r_count == '0);
  // A response with nothing outstanding is dropped even if a push lands the same cycle
  assign w_rsp_pop   = out_valid && !w_empty;
  // A real response in the timeout cycle wins over the timeout
  assign w_timeout   = !out_valid && !w_empty && (r_timer == LP_TMR_LAST);
  assign w_pop       = w_rsp_pop || w_timeout;
  assign w_head_tag  = r_tag_mem[r_rd_ptr];

  // Output stage: load on accept, drop valid once transferred with nothing new behind it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_valid  <= 1'b0;
      r_in_key    <= '0;
      r_in_flag   <= '0;
      r_stage_tag <= '0;
    end else if (w_accept) begin
      r_in_valid  <= 1'b1;
      r_in_key    <= req_key;
      r_in_flag   <= req_flag;
      r_stage_tag <= req_tag;
    end else if (w_push) begin
      r_in_valid  <= 1'b0;
    end
  end

  // Tag storage; contents are don't-care outside the pointer window so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= r_stage_tag;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Timer restarts whenever the head changes, a response arrives, or nothing is outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (out_valid || w_pop || w_empty) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Verdict pulse carrying the retired head tag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_tag     <= '0;
      r_rsp_flag    <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid   <= w_pop;
      r_rsp_timeout <= w_timeout;
      if (w_pop) begin
        r_rsp_tag  <= w_head_tag;
        r_rsp_flag <= w_rsp_pop ? out_flag : '0;
      end
    end
  end

  // Sticky flag for a response that had no outstanding request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (out_valid && w_empty) begin
      r_err <= 1'b1;
    end
  end

  assign req_ready      = w_req_ready;
  assign in_valid       = r_in_valid;
  assign in_key         = r_in_key;
  assign in_flag        = r_in_flag;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_tag        = r_rsp_tag;
  assign rsp_flag       = r_rsp_flag;
  assign rsp_timeout    = r_rsp_timeout;
  assign inflight       = r_count;
  assign err_unexpected = r_err;

endmodule

// File: tb/tb_kvs_lookup_client.sv
// tb/tb_kvs_lookup_client.sv - randomized lockstep bench for kvs_lookup_client against a queue-based model
module tb_kvs_lookup_client;

  localparam int KS    = 96;
  localparam int FS    = 4;
  localparam int TW    = 8;
  localparam int DL    = 3;
  localparam int TO    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_mem;
  logic          req_valid;
  logic          req_ready;
  logic [KS-1:0] req_key;
  logic [FS-1:0] req_flag;
  logic [TW-1:0] req_tag;
  logic [KS-1:0] in_key;
  logic [FS-1:0] in_flag;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic [FS-1:0] out_flag;
  logic          rsp_valid;
  logic [TW-1:0] rsp_tag;
  logic [FS-1:0] rsp_flag;
  logic          rsp_timeout;
  logic [DL:0]   inflight;
  logic          err_unexpected;

  kvs_lookup_client #(
    .KEY_SIZE(KS), .FLAG_SIZE(FS), .TAG_WIDTH(TW), .DEPTH_LOG2(DL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .init_mem(init_mem),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .req_flag(req_flag), .req_tag(req_tag),
    .in_key(in_key), .in_flag(in_flag), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_flag(out_flag),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_flag(rsp_flag),
    .rsp_timeout(rsp_timeout), .inflight(inflight), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Reference model: outstanding tags as a queue, staged request, and the edge at which the head started waiting
  logic [TW-1:0] q[$];
  bit            m_iv;
  logic [KS-1:0] m_key;
  logic [FS-1:0] m_flag;
  logic [TW-1:0] m_tag;
  bit            m_rv;
  bit            m_rto;
  logic [TW-1:0] m_rtag;
  logic [FS-1:0] m_rflag;
  bit            m_err;
  int            edge_n = 0;
  int            head_start = 0;
  int            n_to = 0;
  int            n_resp = 0;
  bit            saw_full = 0;

  task automatic cycle();
    bit rdy, acc, xfer, popr, to, was_empty;
    @(negedge clk);
    rdy = !rst && !init_mem && (!m_iv || in_ready) && (q.size() + int'(m_iv) < DEPTH);
    check("req_ready", 128'(req_ready), 128'(rdy));
    acc  = req_valid && rdy;
    xfer = m_iv && in_ready;
    edge_n++;
    if (rst) begin
      q.delete();
      m_iv = 0; m_key = '0; m_flag = '0; m_tag = '0;
      m_rv = 0; m_rto = 0; m_rtag = '0; m_rflag = '0; m_err = 0;
      head_start = edge_n;
    end else begin
      was_empty = (q.size() == 0);
      popr = out_valid && !was_empty;
      to   = !out_valid && !was_empty && (edge_n - head_start == TO);
      m_rv = popr || to;
      if (m_rv) begin
        m_rtag  = q.pop_front();
        m_rflag = popr ? out_flag : 4'd0;
        m_rto   = to;
        head_start = edge_n;
        if (to) n_to++; else n_resp++;
      end
      if (out_valid && was_empty) m_err = 1;
      if (xfer) begin
        if (q.size() == 0) head_start = edge_n;
        q.push_back(m_tag);
      end
      if (acc) begin
        m_iv = 1; m_key = req_key; m_flag = req_flag; m_tag = req_tag;
      end else if (xfer) begin
        m_iv = 0;
      end
    end
    if (q.size() == DEPTH) saw_full = 1;
    @(posedge clk);
    #1;
    check("in_valid", 128'(in_valid), 128'(m_iv));
    if (m_iv) begin
      check("in_key", 128'(in_key), 128'(m_key));
      check("in_flag", 128'(in_flag), 128'(m_flag));
    end
    check("inflight", 128'(inflight), 128'(q.size()));
    check("rsp_valid", 128'(rsp_valid), 128'(m_rv));
    if (m_rv) begin
      check("rsp_tag", 128'(rsp_tag), 128'(m_rtag));
      check("rsp_flag", 128'(rsp_flag), 128'(m_rflag));
      check("rsp_timeout", 128'(rsp_timeout), 128'(m_rto));
    end
    check("err_unexpected", 128'(err_unexpected), 128'(m_err));
  endtask

  task automatic drive(input int pv, input int pr, input int po, input int pi, input int prst);
    req_valid = ($urandom_range(0, 99) < pv);
    req_key   = {$urandom, $urandom, $urandom};
    req_flag  = FS'($urandom);
    req_tag   = TW'($urandom);
    in_ready  = ($urandom_range(0, 99) < pr);
    out_valid = ($urandom_range(0, 99) < po);
    out_flag  = FS'($urandom);
    init_mem  = ($urandom_range(0, 99) < pi);
    rst       = ($urandom_range(0, 999) < prst);
  endtask

  task automatic run(input int n, input int pv, input int pr, input int po, input int pi, input int prst);
    for (int i = 0; i < n; i++) begin
      drive(pv, pr, po, pi, prst);
      cycle();
    end
  endtask

  initial begin
    rst = 1'b1; init_mem = 1'b0; req_valid = 1'b0; req_key = '0; req_flag = '0;
    req_tag = '0; in_ready = 1'b0; out_valid = 1'b0; out_flag = '0;
    for (int i = 0; i < 3; i++) cycle();
    check("rst_in_key", 128'(in_key), 128'(0));
    check("rst_in_flag", 128'(in_flag), 128'(0));
    check("rst_rsp_tag", 128'(rsp_tag), 128'(0));
    check("rst_rsp_flag", 128'(rsp_flag), 128'(0));
    check("rst_rsp_timeout", 128'(rsp_timeout), 128'(0));

    // General traffic with occasional init_mem
    run(400, 60, 80, 25, 5, 0);
    // Fill to DEPTH with no responses; timeouts retire heads
    run(60, 100, 100, 0, 0, 0);
    // Backpressure from the store
    run(20, 100, 0, 0, 0, 0);
    // Response landing exactly on the timeout cycle
    for (int i = 0; i < 120; i++) begin
      drive(30, 100, 0, 0, 0);
      out_valid = (q.size() > 0) && (edge_n + 1 - head_start == TO);
      cycle();
    end
    // Drain then keep responding with nothing outstanding
    run(30, 0, 100, 100, 0, 0);
    // init_mem holds off new requests
    run(10, 100, 100, 0, 100, 0);
    // Mid-flight reset with requests outstanding
    run(4, 100, 100, 0, 0, 0);
    rst = 1'b1; req_valid = 1'b0; out_valid = 1'b0;
    cycle();
    run(30, 0, 100, 0, 0, 0);
    // Random traffic with sporadic resets
    run(300, 60, 70, 30, 5, 20);

    check("cov_full", 128'(saw_full), 128'(1));
    check("cov_timeout", 128'(n_to > 0), 128'(1));
    check("cov_resp", 128'(n_resp > 0), 128'(1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
